// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RV32I core: fetch/decode/execute/memory/writeback sequencing.
// Moore outputs per state; only FETCH strobes and the MEMWRITE retire also follow mem_ready.
// Memory backpressure: FETCH, MEMREAD and MEMWRITE hold until mem_ready; other states ignore it.
module multicycle_main_fsm #(
  parameter bit EXT_OPS      = 1'b1,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       illegal,
  output logic       retire,
  output logic [3:0] state_dbg
);

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRLINK = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_ILLEGAL  = 4'd15
  } state_t;

  state_t state, state_next;

  assign state_dbg = state;

  // State register; reset overrides every state, including waits and a halted ILLEGAL.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Immediate format straight from the opcode; unknown opcodes fall back to I-type.
  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_SW:            ImmSrc = 3'b001;
      OP_BEQ:           ImmSrc = 3'b010;
      OP_JAL:           ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
      default:          ImmSrc = 3'b000;
    endcase
  end

  // Next-state and Moore outputs; everything defaults to 0, reset then masks the strobes.
  always_comb begin
    state_next = state;
    PCUpdate   = 1'b0;
    Branch     = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    illegal    = 1'b0;
    retire     = 1'b0;

    case (state)
      S_FETCH: begin
        // PC+4 goes straight to the PC while the instruction is latched.
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCUpdate   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute OldPC+imm so branch/jump targets are waiting in ALUOut.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          OP_JALR:      state_next = EXT_OPS ? S_JALR  : S_ILLEGAL;
          OP_LUI:       state_next = EXT_OPS ? S_LUI   : S_ILLEGAL;
          OP_AUIPC:     state_next = EXT_OPS ? S_AUIPC : S_ILLEGAL;
          default:      state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        // MemWrite is held for the whole wait; the store retires when memory accepts it.
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b10;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUOp      = 2'b10;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc  = 2'b00;
        RegWrite   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        // Compare rs1-rs2; the datapath gates the PC write with Zero, target from ALUOut.
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b01;
        ResultSrc  = 2'b00;
        Branch     = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        // Jump to the target in ALUOut while the ALU forms the link OldPC+4.
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b00;
        PCUpdate   = 1'b1;
        state_next = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        PCUpdate   = 1'b1;
        state_next = S_JALRLINK;
      end
      S_JALRLINK: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA    = 2'b11;
        ALUSrcB    = 2'b01;
        state_next = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b01;
        state_next = S_ALUWB;
      end
      S_ILLEGAL: begin
        // Either lock up until reset, or retire the opcode as a NOP.
        illegal = 1'b1;
        if (!ILLEGAL_HALT) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      default: state_next = S_FETCH;
    endcase

    if (reset) begin
      PCUpdate = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      Branch   = 1'b0;
      retire   = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule
